// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT,
      OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of unsigned a*b.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_addend;

  // The product exposes the accumulator after the current step, so the final
  // iteration lands directly in the caller's result register.
  assign w_addend  = r_b[0] ? r_a : '0;
  assign o_product = r_acc + w_addend;
  assign o_done    = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc <= o_product;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes, a flag register and an iterative multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             r_out_valid;
  logic             r_set_pend;
  flags_t           r_flags;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_legal;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_v_add;
  logic             w_v_sub;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  flags_t           w_new_flags;

  assign in_ready = (r_state == IDLE) || ((r_state == OUT) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (op == OP_MUL);
  assign w_legal  = op_legal(op);
  assign w_shamt  = b[SHW-1:0];

  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_v_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign w_v_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOR: w_res = ~(a | b);
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_v_add;
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = w_v_sub;
      end
      // Signed less-than stays correct on overflow by correcting the sign with V.
      OP_SLT: begin
        w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_v_sub};
        w_c   = ~w_diff[WIDTH];
        w_v   = w_v_sub;
      end
      OP_SLL: w_res = a << w_shamt;
      OP_SRL: w_res = a >> w_shamt;
      OP_SRA: w_res = $signed(a) >>> w_shamt;
      default: w_res = '0;
    endcase
  end

  assign w_new_flags = '{n: w_res[WIDTH-1], z: (w_res == '0), c: w_c, v: w_v};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = w_is_mul ? BUSY : OUT;
      BUSY: if (w_mul_done) w_state_next = OUT;
      OUT: begin
        if (w_accept)       w_state_next = w_is_mul ? BUSY : OUT;
        else if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_set_pend  <= 1'b0;
      r_flags     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_set_pend <= set_flags;
        if (w_is_mul) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= 1'b1;
          r_result    <= w_res;
          r_err       <= ~w_legal;
          if (set_flags && w_legal) r_flags <= w_new_flags;
        end
      end else if ((r_state == BUSY) && w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_prod;
        r_err       <= 1'b0;
        if (r_set_pend) r_flags <= '{n: w_mul_prod[WIDTH-1], z: (w_mul_prod == '0), c: 1'b0, v: 1'b0};
      end else if ((r_state == OUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_err   = r_err;
  assign flag_n    = r_flags.n;
  assign flag_z    = r_flags.z;
  assign flag_c    = r_flags.c;
  assign flag_v    = r_flags.v;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-004 Ports, as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid&&in_ready.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- set_flags  in  1  update the flag register with this operation.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- out_err  out  1  illegal opcode.
- flag_n  out  1  negative flag.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.

Function
REQ-005 Opcodes SHALL be: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB (a-b); 0111 SLT (signed a<b -> 1, else 0); 1100 NOR; 1000 SLL; 1001 SRL; 1010 SRA; 1101 MUL (low WIDTH bits of unsigned a*b).
REQ-006 Shifts SHALL shift a by b[SHW-1:0]; b bits above SHW are ignored.
REQ-007 SLT SHALL compare correctly under subtraction overflow (decided by sign of a-b XOR V).
REQ-008 FSM states SHALL be IDLE, BUSY (multiply iterating), OUT (result held).
REQ-009 in_ready SHALL be 1 in IDLE, and in OUT when out_ready=1; 0 in BUSY.
REQ-010 Accepting a non-MUL op SHALL register result and go to OUT next cycle (latency 1).
REQ-011 Accepting MUL SHALL enter BUSY for exactly WIDTH cycles, then OUT (out_valid WIDTH+1 cycles after accept).
REQ-012 In OUT, result/out_err/out_valid SHALL hold stable until out_ready=1.
REQ-013 OUT with out_ready=1 and no accept -> IDLE. Accept in the same cycle -> treated as a fresh accept: OUT for non-MUL (back-to-back, throughput 1/cycle), BUSY for MUL.
REQ-014 Illegal opcode SHALL produce result 0 and out_err=1 with latency 1, with the flags left unchanged.
REQ-015 Flags SHALL update in the cycle result is registered, only if set_flags was 1 at accept and op is legal.
REQ-016 Flag values: N=result[WIDTH-1]; Z=(result==0); ADD: C=carry out, V=signed overflow; SUB/SLT: C=1 when a>=b unsigned (no borrow), V=signed overflow of a-b; all other ops: C=0, V=0.
REQ-017 in_valid with in_ready=0 SHALL be ignored; operands are captured only on accept.

Reset
REQ-018 When rst_n=0 at a rising edge, the block SHALL go to IDLE with out_valid=0, result=0, out_err=0, all flags 0, and the multiply counter=0, regardless of state (including mid-BUSY).
REQ-019 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-020 A shared package alu_pkg SHALL hold the opcode constants, the state enum (IDLE/BUSY/OUT) and the flag struct {n,z,c,v}.
REQ-021 The iterative shift-add multiplier SHALL be one sub-module, alu_mul_iter, with start/done handshake and parameter WIDTH; all other ops are combinational inside alu_pipe.
REQ-022 All outputs SHALL be driven from registers, except in_ready, which is decoded from state and out_ready.

Verification (WIDTH=32)
REQ-023 ADD 0x7FFFFFFF+0x00000001, set_flags=1 -> result 0x80000000, N=1 Z=0 C=0 V=1, out_valid one cycle after accept.
REQ-024 SUB 5-5 then SLT 0x80000000,0x00000001 then SLT 0x7FFFFFFF,0xFFFFFFFF, back-to-back with out_ready=1 -> results 0, 1, 0 on consecutive cycles; flags after SUB are Z=1 C=1.
REQ-025 MUL 0x0000FFFF*0x00010001 -> result 0xFFFFFFFF with out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
REQ-026 Hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> result unchanged, in_ready=0, second op accepted in the cycle out_ready rises.
REQ-027 Assert rst_n=0 at cycle 10 of a MUL -> next cycle IDLE, out_valid=0, flags 0; a following ADD 2+3 returns 5.
REQ-028 op=0100 with set_flags=1 after ADD producing Z=1 -> result 0, out_err=1, flags still Z=1; SRA 0x80000000 by b=0x24 -> shift by 4, result 0xF8000000.
